// File: rtl/ayatsuki_uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and data width.
// A future transmitter imports the same package.
package ayatsuki_uart_rx_pkg;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UART_DATA_W               = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_t;
endpackage

// File: rtl/ayatsuki_uart_rx_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; simultaneous push and pop
// are both honoured when full, and pop is ignored when empty.
module ayatsuki_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head reads as zero while empty so the output is defined without resetting storage.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ayatsuki_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a byte FIFO
// presented as a valid/ready stream with framing-error and overrun pulses.
module ayatsuki_uart_rx
    import ayatsuki_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    // sync2 was already low for the IDLE cycle, so the start check lands HALF cycles after it fell.
    localparam logic [CW-1:0] START_LAST = CW'(HALF - 2);

    rx_state_t              state;
    logic                   sync1;
    logic                   sync2;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;

    assign push     = (state == S_STOP) && (cnt == BIT_LAST) && sync2;
    assign pop      = rx_valid && rx_ready;
    assign rx_valid = !empty;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            cnt       <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!sync2) state <= S_START;
                end
                S_START: begin
                    if (cnt == START_LAST) begin
                        cnt   <= '0;
                        state <= sync2 ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            state   <= S_IDLE;
                            overrun <= full && !pop;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    cnt <= '0;
                    if (sync2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && cnt == BIT_LAST) shreg[bit_idx] <= sync2;
    end

    ayatsuki_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rx_data),
        .full      (full),
        .empty     (empty)
    );
endmodule

// File: tb/tb_ayatsuki_uart_rx.sv
// Bench for ayatsuki_uart_rx: directed scenarios plus random frames checked against
// an expected-byte queue built from the frame rules.
module tb_ayatsuki_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ayatsuki_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: cyc at a negedge equals the index of the posedge just before it.
    int   got_q[$];
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   fe_cyc = -1;
    int   ov_cyc = -1;
    int   valid_rise = -1;
    int   valid_fall = -1;
    int   busy_rise = -1;
    int   busy_fall = -1;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(int'(rx_data));
            if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
            if (overrun)   begin ov_cnt++; ov_cyc = cyc; end
            if (rx_valid && !prev_valid && valid_rise < 0) valid_rise = cyc;
            if (!rx_valid && prev_valid && valid_fall < 0) valid_fall = cyc;
            if (busy && !prev_busy && busy_rise < 0) busy_rise = cyc;
            if (!busy && prev_busy && busy_fall < 0) busy_fall = cyc;
        end
        prev_valid = rx_valid;
        prev_busy  = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm();
        got_q.delete();
        valid_rise = -1;
        valid_fall = -1;
        busy_rise  = -1;
        busy_fall  = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int take_got();
        if (got_q.size() == 0) return -1;
        return got_q.pop_front();
    endfunction

    // Called at a negedge; returns with the stop level still on the line, one bit later.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
        rx = 1'b0;
        t0 = cyc + 1;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
    endtask

    initial begin
        int t0;
        int d;
        int base_fe;
        int base_ov;
        int n_bad;
        int b;
        logic good;
        int exp_q[$];

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        wait_cycles(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        wait_cycles(5);

        // Single byte with exact latency
        arm();
        send_byte(8'hA5, 1'b1, t0);
        check("single_valid_rise", valid_rise, t0 + 153);
        check("single_valid_fall", valid_fall, t0 + 154);
        check("single_busy_rise", busy_rise, t0 + 2);
        check("single_busy_fall", busy_fall, t0 + 153);
        check("single_count", got_q.size(), 1);
        check("single_data", take_got(), 8'hA5);
        wait_cycles(10);

        // Glitch shorter than half a bit
        arm();
        base_fe = fe_cnt;
        rx = 1'b0;
        t0 = cyc + 1;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_busy_rise", busy_rise, t0 + 2);
        check("glitch_busy_fall", busy_fall, t0 + 9);
        check("glitch_no_valid", valid_rise, -1);
        check("glitch_no_fe", fe_cnt - base_fe, 0);

        // Framing error, held break, then a good byte
        arm();
        base_fe = fe_cnt;
        send_byte(8'h3C, 1'b0, t0);
        check("fe_pulse_time", fe_cyc, t0 + 153);
        wait_cycles(40);
        rx = 1'b1;
        d = cyc;
        wait_cycles(32);
        check("fe_wait_idle_exit", busy_fall, d + 3);
        send_byte(8'h11, 1'b1, t0);
        wait_cycles(5);
        check("fe_pulse_count", fe_cnt - base_fe, 1);
        check("fe_count", got_q.size(), 1);
        check("fe_next_data", take_got(), 8'h11);

        // Overrun with the consumer stalled
        arm();
        base_ov = ov_cnt;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, t0);
        wait_cycles(5);
        check("ov_pulse_count", ov_cnt - base_ov, 1);
        check("ov_pulse_time", ov_cyc, t0 + 153);
        check("ov_head_valid", rx_valid, 1);
        check("ov_head_data", rx_data, 8'h01);
        check("ov_nothing_popped", got_q.size(), 0);
        rx_ready = 1'b1;
        wait_cycles(8);
        check("ov_drain_count", got_q.size(), 4);
        for (int i = 1; i <= 4; i++) check("ov_drain_data", take_got(), i);
        check("ov_drained_valid", rx_valid, 0);

        // Back-to-back frames
        arm();
        base_fe = fe_cnt;
        base_ov = ov_cnt;
        send_byte(8'h00, 1'b1, t0);
        send_byte(8'hFF, 1'b1, t0);
        wait_cycles(5);
        check("b2b_count", got_q.size(), 2);
        check("b2b_first", take_got(), 8'h00);
        check("b2b_second", take_got(), 8'hFF);
        check("b2b_no_fe", fe_cnt - base_fe, 0);
        check("b2b_no_ov", ov_cnt - base_ov, 0);

        // Reset during data bit 3 with a byte already queued
        arm();
        base_fe = fe_cnt;
        rx_ready = 1'b0;
        send_byte(8'h77, 1'b1, t0);
        rx = 1'b0;
        wait_cycles(CPB * 4 + CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        rx_ready = 1'b1;
        wait_cycles(40);
        check("rst_no_bytes", got_q.size(), 0);
        check("rst_no_fe", fe_cnt - base_fe, 0);
        send_byte(8'h5A, 1'b1, t0);
        wait_cycles(5);
        check("rst_after_count", got_q.size(), 1);
        check("rst_after_data", take_got(), 8'h5A);

        // Random frames, some with a bad stop bit
        arm();
        base_fe = fe_cnt;
        base_ov = ov_cnt;
        n_bad = 0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            b    = int'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_byte(8'(b), good, t0);
            if (good) begin
                exp_q.push_back(b);
                wait_cycles(int'($urandom_range(0, 20)));
            end else begin
                n_bad++;
                wait_cycles(int'($urandom_range(0, 30)));
                rx = 1'b1;
                wait_cycles(int'($urandom_range(8, 40)));
            end
        end
        wait_cycles(10);
        check("rand_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0) check("rand_data", take_got(), exp_q.pop_front());
        check("rand_fe", fe_cnt - base_fe, n_bad);
        check("rand_ov", ov_cnt - base_ov, 0);
        check("rand_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
